// File: rtl/trap_csr_unit.sv
// trap_csr_unit
//   Machine-mode CSR file and trap commit unit. Sits directly after the
//   exception arbitration stage. It records committed traps into
//   mepc/mcause/mtval/mstatus and hands the trap entry address back upstream.
//   It also executes Zicsr read/modify/write requests and mret, and keeps the
//   64-bit mcycle/minstret counters.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   exc_valid         one-cycle trap commit pulse with exc_code/exc_pc/exc_val
//   mret_valid        one-cycle mret commit pulse
//   csr_req/op/addr   CSR instruction commit (op 01 RW, 10 RS, 11 RC, 00 none)
//   csr_wdata         rs1 value or zero-extended immediate
//   csr_rdata         combinational old value of the addressed CSR
//   csr_illegal       combinational illegal-access flag, only while csr_req
//   instr_retire      one instruction retired this cycle
//   trap_vector       combinational trap entry address
//   redirect          registered one-cycle redirect pulse
//   redirect_target   registered redirect PC
module trap_csr_unit #(
  parameter logic [31:0] MARCHID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_val,
  input  logic        mret_valid,
  input  logic        csr_req,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        instr_retire,
  output logic [31:0] trap_vector,
  output logic        redirect,
  output logic [31:0] redirect_target
);

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [3:0]  r_mcause;
  logic [31:0] r_mtval;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic        r_redirect;
  logic [31:0] r_redirect_target;

  logic [31:0] w_rdata;
  logic        w_known;
  logic        w_is_write;
  logic        w_read_only;
  logic        w_csr_we;
  logic [31:0] w_new;
  logic [63:0] w_mcycle_next;
  logic [63:0] w_minstret_next;

  // Read mux: every known address returns its architectural view.
  always_comb begin
    w_rdata = 32'h0;
    w_known = 1'b1;
    case (csr_addr)
      A_MSTATUS:   w_rdata = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
      A_MTVEC:     w_rdata = r_mtvec;
      A_MSCRATCH:  w_rdata = r_mscratch;
      A_MEPC:      w_rdata = r_mepc;
      A_MCAUSE:    w_rdata = {28'b0, r_mcause};
      A_MTVAL:     w_rdata = r_mtval;
      A_MCYCLE:    w_rdata = r_mcycle[31:0];
      A_MCYCLEH:   w_rdata = r_mcycle[63:32];
      A_MINSTRET:  w_rdata = r_minstret[31:0];
      A_MINSTRETH: w_rdata = r_minstret[63:32];
      A_MVENDORID: w_rdata = 32'h0;
      A_MARCHID:   w_rdata = MARCHID;
      default: begin
        w_rdata = 32'h0;
        w_known = 1'b0;
      end
    endcase
  end

  // RS/RC with a zero mask are pure reads and must not trip the
  // read-only check.
  assign w_is_write  = (csr_op == OP_RW) ||
                       (((csr_op == OP_RS) || (csr_op == OP_RC)) && (csr_wdata != 32'h0));
  assign w_read_only = (csr_addr[11:10] == 2'b11);

  assign csr_rdata   = w_rdata;
  assign csr_illegal = csr_req && (!w_known || (w_read_only && w_is_write));

  // A trap or an mret in the same cycle suppresses the CSR write.
  assign w_csr_we = csr_req && w_known && !w_read_only && w_is_write &&
                    !exc_valid && !mret_valid;

  always_comb begin
    w_new = w_rdata;
    case (csr_op)
      OP_RW:   w_new = csr_wdata;
      OP_RS:   w_new = w_rdata | csr_wdata;
      OP_RC:   w_new = w_rdata & ~csr_wdata;
      default: w_new = w_rdata;
    endcase
  end

  // Writing either half of a counter replaces that half and skips the
  // increment for that cycle; the untouched half keeps its old value.
  always_comb begin
    w_mcycle_next   = r_mcycle + 64'd1;
    w_minstret_next = r_minstret + {63'd0, (instr_retire && !exc_valid)};
    if (w_csr_we) begin
      case (csr_addr)
        A_MCYCLE:    w_mcycle_next   = {r_mcycle[63:32], w_new};
        A_MCYCLEH:   w_mcycle_next   = {w_new, r_mcycle[31:0]};
        A_MINSTRET:  w_minstret_next = {r_minstret[63:32], w_new};
        A_MINSTRETH: w_minstret_next = {w_new, r_minstret[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mie             <= 1'b0;
      r_mpie            <= 1'b0;
      r_mtvec           <= MTVEC_RESET & ~32'h3;
      r_mscratch        <= 32'h0;
      r_mepc            <= 32'h0;
      r_mcause          <= 4'h0;
      r_mtval           <= 32'h0;
      r_mcycle          <= 64'h0;
      r_minstret        <= 64'h0;
      r_redirect        <= 1'b0;
      r_redirect_target <= 32'h0;
    end else begin
      r_mcycle   <= w_mcycle_next;
      r_minstret <= w_minstret_next;
      r_redirect <= 1'b0;
      if (exc_valid) begin
        r_mepc            <= exc_pc & ~32'h3;
        r_mcause          <= exc_code;
        r_mtval           <= exc_val;
        r_mpie            <= r_mie;
        r_mie             <= 1'b0;
        r_redirect        <= 1'b1;
        r_redirect_target <= r_mtvec;
      end else if (mret_valid) begin
        r_mie             <= r_mpie;
        r_mpie            <= 1'b1;
        r_redirect        <= 1'b1;
        r_redirect_target <= r_mepc;
      end else if (w_csr_we) begin
        case (csr_addr)
          A_MSTATUS: begin
            r_mie  <= w_new[3];
            r_mpie <= w_new[7];
          end
          A_MTVEC:    r_mtvec    <= w_new & ~32'h3;
          A_MSCRATCH: r_mscratch <= w_new;
          A_MEPC:     r_mepc     <= w_new & ~32'h3;
          A_MCAUSE:   r_mcause   <= w_new[3:0];
          A_MTVAL:    r_mtval    <= w_new;
          default: ;
        endcase
      end
    end
  end

  // mtvec is stored with bits 1:0 already cleared, so it is the entry address.
  assign trap_vector     = r_mtvec;
  assign redirect        = r_redirect;
  assign redirect_target = r_redirect_target;

endmodule

// File: tb/tb_trap_csr_unit.sv
// tb_trap_csr_unit
//   Drives directed scenarios and then random traffic into trap_csr_unit and
//   compares every cycle against a behavioural model of the CSR file.
module tb_trap_csr_unit;

  localparam logic [31:0] MARCHID_P = 32'h1234_5678;
  localparam logic [31:0] MTVEC_P   = 32'h8000_0002;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;
  logic [31:0] exc_val;
  logic        mret_valid;
  logic        csr_req;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        instr_retire;
  logic [31:0] trap_vector;
  logic        redirect;
  logic [31:0] redirect_target;

  always #5 clk = ~clk;

  trap_csr_unit #(.MARCHID(MARCHID_P), .MTVEC_RESET(MTVEC_P)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_val(exc_val),
    .mret_valid(mret_valid),
    .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .instr_retire(instr_retire),
    .trap_vector(trap_vector),
    .redirect(redirect), .redirect_target(redirect_target)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural model: architectural CSR state as plain variables.
  bit        m_mie, m_mpie;
  bit [31:0] m_mtvec, m_mscratch, m_mepc, m_mtval;
  bit [3:0]  m_mcause;
  bit [63:0] m_mcycle, m_minstret;
  bit        m_redir;
  bit [31:0] m_tgt;

  function automatic bit [31:0] m_mstatus();
    return 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
  endfunction

  function automatic void model_read(input bit [11:0] a, output bit [31:0] v, output bit known);
    known = 1'b1;
    v     = 32'h0;
    case (a)
      12'h300: v = m_mstatus();
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = {28'h0, m_mcause};
      12'h343: v = m_mtval;
      12'hB00: v = m_mcycle[31:0];
      12'hB80: v = m_mcycle[63:32];
      12'hB02: v = m_minstret[31:0];
      12'hB82: v = m_minstret[63:32];
      12'hF11: v = 32'h0;
      12'hF12: v = MARCHID_P;
      default: known = 1'b0;
    endcase
  endfunction

  function automatic bit is_write(input bit [1:0] op, input bit [31:0] wd);
    return (op == 2'b01) || ((op != 2'b00) && (wd != 32'h0));
  endfunction

  function automatic void model_update();
    bit [31:0] old_v, nv;
    bit        known;
    bit [63:0] nc, ni;
    if (rst) begin
      m_mie = 0; m_mpie = 0; m_mtvec = MTVEC_P & ~32'h3;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_mcycle = 0; m_minstret = 0; m_redir = 0; m_tgt = 0;
      return;
    end
    nc = m_mcycle + 1;
    ni = m_minstret + ((instr_retire && !exc_valid) ? 64'd1 : 64'd0);
    model_read(csr_addr, old_v, known);
    if (exc_valid) begin
      m_redir  = 1; m_tgt = m_mtvec;
      m_mepc   = exc_pc & ~32'h3;
      m_mcause = exc_code;
      m_mtval  = exc_val;
      m_mpie   = m_mie; m_mie = 0;
    end else if (mret_valid) begin
      m_redir = 1; m_tgt = m_mepc;
      m_mie   = m_mpie; m_mpie = 1;
    end else begin
      m_redir = 0;
      if (csr_req && known && csr_addr < 12'hC00 && is_write(csr_op, csr_wdata)) begin
        case (csr_op)
          2'b01:   nv = csr_wdata;
          2'b10:   nv = old_v | csr_wdata;
          default: nv = old_v & ~csr_wdata;
        endcase
        case (csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec    = nv & ~32'h3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc     = nv & ~32'h3;
          12'h342: m_mcause   = nv[3:0];
          12'h343: m_mtval    = nv;
          12'hB00: nc = {m_mcycle[63:32], nv};
          12'hB80: nc = {nv, m_mcycle[31:0]};
          12'hB02: ni = {m_minstret[63:32], nv};
          12'hB82: ni = {nv, m_minstret[31:0]};
          default: ;
        endcase
      end
    end
    m_mcycle   = nc;
    m_minstret = ni;
  endfunction

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic step();
    bit [31:0] v;
    bit        known, exp_ill;
    @(negedge clk);
    model_read(csr_addr, v, known);
    exp_ill = csr_req && (!known || (csr_addr >= 12'hC00 && is_write(csr_op, csr_wdata)));
    $display("t=%0t rst=%0b exc=%0b mret=%0b req=%0b op=%0d addr=%h wd=%h ret=%0b rdata=%h ill=%0b redir=%0b tgt=%h",
             $time, rst, exc_valid, mret_valid, csr_req, csr_op, csr_addr, csr_wdata,
             instr_retire, csr_rdata, csr_illegal, redirect, redirect_target);
    chk("rdata", csr_rdata, v);
    chk("illegal", csr_illegal, exp_ill);
    chk("trap_vector", trap_vector, m_mtvec);
    chk("redirect", redirect, m_redir);
    chk("redirect_target", redirect_target, m_tgt);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_val = 0;
    mret_valid = 0; csr_req = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    instr_retire = 0;
  endtask

  task automatic csr(input bit [1:0] op, input bit [11:0] a, input bit [31:0] wd);
    csr_req = 1; csr_op = op; csr_addr = a; csr_wdata = wd;
  endtask

  task automatic trap(input bit [3:0] c, input bit [31:0] pc, input bit [31:0] val);
    exc_valid = 1; exc_code = c; exc_pc = pc; exc_val = val;
  endtask

  bit [11:0] addr_tab [12] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                               12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12};

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    model_update();
    #1;
    // Reset must win over a simultaneous trap.
    trap(4'h7, 32'h1234_5678, 32'hDEAD_BEEF);
    step();
    idle();
    chk("rst_redirect", redirect, 1'b0);

    // Reset values.
    csr(2'b10, 12'h305, 0); #1;
    chk("rst_mtvec", csr_rdata, 32'h8000_0000);
    chk("rst_ill", csr_illegal, 1'b0);
    step();
    csr(2'b10, 12'h300, 0); #1;
    chk("rst_mstatus", csr_rdata, 32'h0000_1800);
    step();

    // mtvec write then trap.
    idle(); csr(2'b01, 12'h305, 32'h8000_0103); step();
    idle(); trap(4'h2, 32'h8000_0046, 32'hFFFF_FFFF); #1;
    chk("tv_after_write", trap_vector, 32'h8000_0100);
    step();
    idle(); csr(2'b10, 12'h341, 0); #1;
    chk("trap_redirect", redirect, 1'b1);
    chk("trap_target", redirect_target, 32'h8000_0100);
    chk("mepc", csr_rdata, 32'h8000_0044);
    step();
    idle(); csr(2'b10, 12'h342, 0); #1;
    chk("redirect_pulse_end", redirect, 1'b0);
    chk("mcause", csr_rdata, 32'h2);
    step();
    idle(); csr(2'b10, 12'h343, 0); #1;
    chk("mtval", csr_rdata, 32'hFFFF_FFFF);
    step();

    // MIE set, trap, mret.
    idle(); csr(2'b10, 12'h300, 32'h8); step();
    idle(); trap(4'h5, 32'h0000_0100, 0); step();
    idle(); csr(2'b10, 12'h300, 0); #1;
    chk("mstatus_trap", csr_rdata, 32'h0000_1880);
    step();
    idle(); mret_valid = 1; step();
    idle(); csr(2'b10, 12'h300, 0); #1;
    chk("mstatus_mret", csr_rdata, 32'h0000_1888);
    chk("mret_redirect", redirect, 1'b1);
    chk("mret_target", redirect_target, 32'h0000_0100);
    step();

    // Simultaneous trap, mret and CSR write: only the trap commits.
    idle(); trap(4'h3, 32'h0000_0200, 32'h55); mret_valid = 1;
    csr(2'b01, 12'h340, 32'h1234); step();
    idle(); csr(2'b10, 12'h340, 0); #1;
    chk("mscratch_kept", csr_rdata, 32'h0);
    chk("simul_target", redirect_target, 32'h8000_0100);
    step();

    // Read-only and unknown addresses.
    idle(); csr(2'b01, 12'hF11, 32'h5); #1;
    chk("ro_write_ill", csr_illegal, 1'b1);
    step();
    idle(); csr(2'b10, 12'hF12, 0); #1;
    chk("marchid", csr_rdata, MARCHID_P);
    chk("ro_read_ok", csr_illegal, 1'b0);
    step();
    idle(); csr(2'b01, 12'h7C0, 32'h9); #1;
    chk("unknown_ill", csr_illegal, 1'b1);
    chk("unknown_rdata", csr_rdata, 32'h0);
    step();

    // Counter half writes.
    idle(); csr(2'b01, 12'hB00, 32'hFFFF_FFFF); step();
    idle(); csr(2'b01, 12'hB80, 32'h0); step();
    idle(); step();
    idle(); csr(2'b10, 12'hB80, 0); #1;
    chk("mcycleh", csr_rdata, 32'h1);
    step();
    idle(); csr(2'b10, 12'hB00, 0); #1;
    chk("mcycle_lo", csr_rdata, 32'h1);
    step();

    // minstret: write suppresses increment, trap cycle does not count.
    idle(); csr(2'b01, 12'hB02, 0); instr_retire = 1; step();
    idle(); trap(4'h1, 32'h40, 0); instr_retire = 1; step();
    idle(); instr_retire = 1; step();
    idle(); csr(2'b10, 12'hB02, 0); #1;
    chk("minstret", csr_rdata, 32'h1);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      idle();
      rst          = ($urandom_range(0, 99) == 0);
      exc_valid    = ($urandom_range(0, 9) == 0);
      exc_code     = 4'($urandom);
      exc_pc       = $urandom;
      exc_val      = $urandom;
      mret_valid   = ($urandom_range(0, 9) == 0);
      csr_req      = ($urandom_range(0, 1) == 1);
      csr_op       = 2'($urandom);
      csr_addr     = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 11)];
      csr_wdata    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      instr_retire = ($urandom_range(0, 1) == 1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
